if_fetch_queue: RTL and testbench
=================================

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter PC_W, default 9: fetch address width in bytes.
REQ-002 Parameter INS_W, default 32: instruction width.
REQ-003 Parameter FQ_DEPTH, default 4: prefetch queue entries, power of two, at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 redirect  in  1  flush/redirect from the branch unit (PcSel).
REQ-007 redirect_pc  in  PC_W  new fetch address, valid when redirect=1.
REQ-008 stall  in  1  hazard stall (Reg_Stall); blocks consumption of the head entry.
REQ-009 imem_req  out  1  instruction-memory request valid.
REQ-010 imem_addr  out  PC_W  request address.
REQ-011 imem_ready  in  1  memory accepts the request this cycle.
REQ-012 imem_rvalid  in  1  response valid; responses are in order, at least 1 cycle after acceptance.
REQ-013 imem_rdata  in  INS_W  response instruction.
REQ-014 fetch_valid  out  1  queue head valid, feeds IF/ID.
REQ-015 fetch_pc  out  PC_W  PC of the head entry.
REQ-016 fetch_instr  out  INS_W  instruction of the head entry.

Function
REQ-017 The fetch FSM SHALL have three states: IDLE (no request outstanding), WAIT (one request accepted, response pending) and DROP (outstanding response to be discarded).
REQ-018 At most one request SHALL be outstanding at any time.
REQ-019 imem_req SHALL be 1 only when all of these hold: redirect=0; state is IDLE, or state is WAIT with imem_rvalid=1; count + (1 if the response is arriving this cycle) < FQ_DEPTH. Concurrent pops SHALL be ignored for this check.
REQ-020 imem_addr SHALL equal the next-PC register and SHALL stay stable while imem_req=1 and imem_ready=0.
REQ-021 When imem_req=1 and imem_ready=1: the FSM SHALL move to WAIT, the next-PC register SHALL add 4 (modulo 2^PC_W), and the request PC SHALL be latched.
REQ-022 When imem_rvalid=1 in WAIT, {latched PC, imem_rdata} SHALL be pushed. The FSM SHALL then go to IDLE, or remain in WAIT if a new request is accepted in the same cycle.
REQ-023 A pop SHALL occur when fetch_valid=1, stall=0 and redirect=0. fetch_valid, fetch_pc and fetch_instr SHALL be driven combinationally from the queue head.
REQ-024 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged.
REQ-025 On redirect=1 the queue SHALL be emptied, so fetch_valid=0 next cycle. The next-PC register SHALL load {redirect_pc[PC_W-1:2],2'b00}.
REQ-026 When redirect=1 arrives in WAIT, the FSM SHALL go to DROP if imem_rvalid=0, or to IDLE with the response discarded if imem_rvalid=1.
REQ-027 In DROP, the first imem_rvalid SHALL be discarded and the FSM SHALL return to IDLE. A redirect received in DROP SHALL update the next-PC register only.
REQ-028 imem_rvalid received in IDLE SHALL be ignored.
REQ-029 When the queue is full, no request SHALL issue. When it is empty, fetch_valid SHALL be 0; there is no same-cycle bypass from imem_rdata.

Reset
REQ-030 On reset=1: next-PC = 0, FSM = IDLE, queue empty, imem_req = 0, fetch_valid = 0, fetch_pc = 0, fetch_instr = 0, and all counters = 0.
REQ-031 Reset SHALL override redirect, stall and any outstanding response. A response arriving after reset deasserts SHALL be ignored, because the FSM is in IDLE.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN, when defined, SHALL add three outputs:
- fq_fetched (32 bits): accepted requests.
- fq_dropped (32 bits): discarded responses plus entries flushed by redirect.
- fq_stall_cycles (32 bits): cycles with stall=1 and fetch_valid=1.
All three SHALL wrap at 2^32 and reset to 0.
REQ-033 Without FETCH_PERF_CNT_EN, these ports and their logic SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-034 The enum fetch_state_t {IDLE, WAIT, DROP} and the struct fq_entry_t {pc, instr} SHALL live in Pipe_Buf_Reg_PKG, together with the default FQ_DEPTH constant.
REQ-035 Queue storage SHALL be one sub-module, fetch_fifo, with read/write pointers, a count, push/pop/flush inputs, and full/empty outputs.

Verification
REQ-036 Reset, then imem_ready=1 and rvalid one cycle after each accept with rdata=0x00000013 -> fetch_pc sequence 0x000, 0x004, 0x008; fetch_valid=1 from cycle 3.
REQ-037 stall=1 held for 10 cycles -> queue fills to 4 entries, imem_req=0 while full, fetch_pc stays at 0x000. Release stall -> pops in order 0x000 to 0x00C.
REQ-038 redirect=1 with redirect_pc=0x0A6 while in WAIT with no rvalid -> FSM enters DROP and the next rvalid is discarded; the next request is to 0x0A4 and fetch_valid=0 until its response arrives.
REQ-039 redirect and imem_rvalid in the same cycle -> response not enqueued, no imem_req that cycle, fetch_valid=0 next cycle.
REQ-040 Next-PC at 0x1FC, accept -> next imem_addr=0x000 (wrap). Assert reset while in WAIT, then rvalid -> fetch_valid stays 0 and next-PC=0.
REQ-041 With FETCH_PERF_CNT_EN, run REQ-038 -> fq_dropped is incremented by the discarded response plus the flushed entry count.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the instruction-fetch prefetch queue.
package Pipe_Buf_Reg_PKG;

  localparam int FQ_DEPTH_DEF = 4;
  localparam int PC_W_DEF     = 9;
  localparam int INS_W_DEF    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W_DEF-1:0]  pc;
    logic [INS_W_DEF-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Circular prefetch storage: read/write pointers plus an occupancy count.
module fetch_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok, push_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o;
  // A full queue still accepts a write when the head leaves in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    rptr_d  = rptr_q + AW'(pop_ok);
    wptr_d  = wptr_q + AW'(push_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i && !reset) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a single-outstanding memory FSM feeding a prefetch queue.
// Optional perf counters are compiled in with FETCH_PERF_CNT_EN.
module if_fetch_queue
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int PC_W     = 9,
  parameter int INS_W    = 32,
  parameter int FQ_DEPTH = FQ_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             fetch_valid,
  output logic [PC_W-1:0]  fetch_pc,
  output logic [INS_W-1:0] fetch_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      fq_fetched,
  output logic [31:0]      fq_dropped,
  output logic [31:0]      fq_stall_cycles
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam int EW = PC_W + INS_W;

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  npc_q, npc_d, rpc_q, rpc_d;
  logic [CW-1:0]    count;
  logic [CW:0]      occ;
  logic             full, empty;
  logic             rsp_arrive, accept, push, pop;
  logic [EW-1:0]    head;
  logic [1:0]       unused_pc_lsb;

  assign unused_pc_lsb = redirect_pc[1:0];

  assign rsp_arrive = (state_q == WAIT) && imem_rvalid;
  // Occupancy check counts the arriving response but ignores a concurrent pop.
  assign occ        = {1'b0, count} + (CW+1)'(rsp_arrive);
  assign imem_req   = !reset && !redirect && ((state_q == IDLE) || rsp_arrive)
                      && (occ < (CW+1)'(FQ_DEPTH));
  assign imem_addr  = npc_q;
  assign accept     = imem_req && imem_ready;
  assign push       = rsp_arrive && !redirect;
  assign pop        = fetch_valid && !stall && !redirect;

  fetch_fifo #(.W(EW), .DEPTH(FQ_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i ({rpc_q, imem_rdata}),
    .pop_i   (pop),
    .flush_i (redirect),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign fetch_valid = !reset && !empty;
  assign fetch_pc    = fetch_valid ? head[INS_W +: PC_W] : '0;
  assign fetch_instr = fetch_valid ? head[INS_W-1:0]     : '0;

  always_comb begin
    state_d = state_q;
    npc_d   = npc_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: begin
        if (redirect)         state_d = imem_rvalid ? IDLE : DROP;
        else if (imem_rvalid) state_d = accept ? WAIT : IDLE;
      end
      DROP: if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      npc_d = {redirect_pc[PC_W-1:2], 2'b00};
    end else if (accept) begin
      npc_d = npc_q + PC_W'(4);
      rpc_d = npc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      npc_q   <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      npc_q   <= npc_d;
      rpc_q   <= rpc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, dropped_q, stallc_q;
  logic        discard;

  assign discard = imem_rvalid && (((state_q == WAIT) && redirect) || (state_q == DROP));

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= '0;
      dropped_q <= '0;
      stallc_q  <= '0;
    end else begin
      fetched_q <= fetched_q + 32'(accept);
      dropped_q <= dropped_q + 32'(discard) + (redirect ? 32'(count) : 32'd0);
      stallc_q  <= stallc_q + 32'(stall && fetch_valid);
    end
  end

  assign fq_fetched      = fetched_q;
  assign fq_dropped      = dropped_q;
  assign fq_stall_cycles = stallc_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench: memory responder, queue-based reference model and pop scoreboard.
module tb_if_fetch_queue;
  import Pipe_Buf_Reg_PKG::*;

  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;
  localparam int NCYC  = 3000;

  logic             clk = 1'b0;
  logic             reset, redirect, stall, imem_ready, imem_rvalid;
  logic [PC_W-1:0]  redirect_pc, imem_addr, fetch_pc;
  logic [INS_W-1:0] imem_rdata, fetch_instr;
  logic             imem_req, fetch_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]      fq_fetched, fq_dropped, fq_stall_cycles;
`endif

  always #5 clk = ~clk;

  if_fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .FQ_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fq_fetched      (fq_fetched),
    .fq_dropped      (fq_dropped),
    .fq_stall_cycles (fq_stall_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of expected entries and a description of the one
  // in-flight request (whether there is one, whether it will be thrown away).
  fq_entry_t       exp_q[$];
  bit              m_out, m_disc;
  logic [PC_W-1:0] m_npc, m_lpc;
  longint          m_fetched, m_dropped, m_stallc;

  // Memory responder state.
  bit              mem_busy, prev_acc, prev_rv;
  int              mem_cnt;
  logic [INS_W-1:0] mem_data;

  // Scoreboard monitor: every DUT pop must match the oldest expected entry.
  always @(negedge clk) begin
    #2;
    if (fetch_valid && !stall && !redirect && !reset) begin
      if (exp_q.size() == 0) begin
        check("pop_underflow", 64'(fetch_pc), 64'h1_0000);
      end else begin
        fq_entry_t e;
        e = exp_q.pop_front();
        check("pop_pc", 64'(fetch_pc), 64'(e.pc));
        check("pop_instr", 64'(fetch_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    m_out = 0; m_disc = 0; m_npc = '0; m_lpc = '0;
    m_fetched = 0; m_dropped = 0; m_stallc = 0;
    mem_busy = 0; prev_acc = 0; prev_rv = 0; mem_cnt = 0; mem_data = '0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int  phase;
      bit  arriving, e_req, e_val, e_acc, discarded;
      int  flushed;
      @(negedge clk);
      phase = (cyc < 150) ? 0 : (cyc < 500) ? 1 : 2;

      // Memory: in-order, one outstanding, response >= 1 cycle after accept.
      if (prev_rv) mem_busy = 0;
      if (prev_acc) begin
        mem_busy = 1;
        mem_cnt  = (phase == 0) ? 0 : int'($urandom_range(0, 3));
        mem_data = (phase == 0) ? 32'h0000_0013 : $urandom;
      end else if (mem_busy && mem_cnt > 0) begin
        mem_cnt--;
      end
      imem_rvalid = mem_busy && (mem_cnt == 0);
      imem_rdata  = imem_rvalid ? mem_data : $urandom;
      prev_rv     = imem_rvalid;
      if (!mem_busy && phase == 2 && $urandom_range(0, 9) == 0) imem_rvalid = 1'b1;
      imem_ready  = (!mem_busy || prev_rv) && (phase == 0 || $urandom_range(0, 3) != 0);

      reset       = (cyc < 3) || (phase == 2 && $urandom_range(0, 99) == 0);
      stall       = (phase == 1) ? ($urandom_range(0, 9) != 0)
                  : (phase == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      redirect    = (phase == 1) ? ($urandom_range(0, 49) == 0)
                  : (phase == 2) ? ($urandom_range(0, 19) == 0) : 1'b0;
      redirect_pc = PC_W'($urandom);

      #1;
      arriving = m_out && !m_disc && imem_rvalid;
      e_req = !reset && !redirect && (!m_out || arriving)
              && ((exp_q.size() + int'(arriving)) < DEPTH);
      e_val = !reset && (exp_q.size() > 0);
      check("imem_req", 64'(imem_req), 64'(e_req));
      if (e_req) check("imem_addr", 64'(imem_addr), 64'(m_npc));
      check("fetch_valid", 64'(fetch_valid), 64'(e_val));
      if (reset) begin
        check("rst_fetch_pc", 64'(fetch_pc), 64'h0);
        check("rst_fetch_instr", 64'(fetch_instr), 64'h0);
      end
`ifdef FETCH_PERF_CNT_EN
      check("fq_fetched", 64'(fq_fetched), 64'(m_fetched[31:0]));
      check("fq_dropped", 64'(fq_dropped), 64'(m_dropped[31:0]));
      check("fq_stall_cycles", 64'(fq_stall_cycles), 64'(m_stallc[31:0]));
`endif
      prev_acc = imem_req && imem_ready;

      #2;
      if (reset) begin
        exp_q.delete();
        m_npc = '0; m_out = 0; m_disc = 0;
        m_fetched = 0; m_dropped = 0; m_stallc = 0;
      end else begin
        e_acc     = e_req && imem_ready;
        discarded = 0;
        flushed   = 0;
        if (m_out && imem_rvalid) begin
          if (m_disc || redirect) discarded = 1;
          else exp_q.push_back('{pc: m_lpc, instr: imem_rdata});
          m_out  = 0;
          m_disc = 0;
        end
        if (redirect) begin
          flushed = exp_q.size();
          exp_q.delete();
          m_npc = redirect_pc & ~PC_W'(3);
          if (m_out) m_disc = 1;
        end
        if (e_acc) begin
          m_out  = 1;
          m_disc = 0;
          m_lpc  = m_npc;
          m_npc  = PC_W'(m_npc + 4);
        end
        m_fetched += longint'(e_acc);
        m_dropped += longint'(discarded) + longint'(flushed);
        m_stallc  += longint'(stall && e_val);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
